l1_rd_sched: RTL and testbench
==============================

// Module: l1_rd_sched
// PURPOSE
//  Per-cycle scheduler for the L1 read ports. Collects read requests from nreq requesters,
//  grants up to nports per cycle in round-robin order, gated by per-stream read credits
//  (reads known to be resident in L1). Drives the per-port act/sid vectors consumed by the
//  L1 read-port array through one registered output stage.
// PARAMETERS
//  nstrms        64                  number of streams
//  nstrms_width  $clog2(nstrms)      stream id width
//  nports        8                   L1 read ports (grants per cycle, max)
//  nreq          8                   requesters; nreq >= nports
//  cnt_width     8                   per-stream credit counter width
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-high reset
//  i_req_v    in   nreq                request valid per requester
//  i_req_r    out  nreq                request accepted (grant) per requester
//  i_req_sid  in   nreq*nstrms_width   requested stream id per requester
//  i_cr_v     in   1                   credit add valid (L1 fill completed)
//  i_cr_sid   in   nstrms_width        stream receiving credits
//  i_cr_cnt   in   cnt_width           credits added
//  i_clr      in   nstrms              per-stream credit clear (stream reset/end)
//  o_rd_v     out  1                   registered grant bundle valid
//  o_rd_r     in   1                   downstream accepts bundle
//  o_rd_acts  out  nports              port k active in bundle
//  o_rd_sids  out  nports*nstrms_width stream id per port (0 when inactive)
//  o_credits  out  nstrms*cnt_width    current credit counters (debug/status)
// BEHAVIOUR
//  - Reset: o_rd_v=0, o_rd_acts=0, o_rd_sids=0, all credits=0, rr pointer=0, i_req_r=0.
//  - Stall: when o_rd_v & ~o_rd_r, no grants issued (i_req_r=0), output held stable.
//  - Scan: requesters examined in order rr, rr+1, ... (mod nreq). Requester j granted iff
//    i_req_v[j], fewer than nports grants so far this cycle, i_clr[sid] low, and
//    credit[sid] > number of earlier grants to same sid this cycle. Non-granted requesters
//    do not block later ones (no head-of-line blocking).
//  - k-th grant in scan order (k=0..) occupies port k; ports >= grant count inactive.
//    Same-sid grants thus appear in port order, matching ascending pointer offsets.
//  - i_req_r[j] combinational, same cycle as scan; handshake is i_req_v & i_req_r.
//  - Bundle registered: o_rd_v=1 next cycle iff >=1 grant; latency request->output 1 cycle.
//    Zero-grant cycle with o_rd_r (or o_rd_v low) loads o_rd_v=0.
//  - rr pointer: after >=1 grant, rr <= (index of last granted requester + 1) mod nreq;
//    unchanged when no grant.
//  - Credits per stream s, each cycle: next = clr ? 0 : sat(cur + add - used), where
//    add = i_cr_cnt if i_cr_v & i_cr_sid==s, used = grants to s this cycle.
//    Add and consume same cycle: net applied; credits added this cycle not usable until next.
//    Saturate at 2^cnt_width-1 on overflow; used never exceeds cur (by grant rule).
//  - i_clr[s] priority over add and grants for s in that cycle; bundle already in output
//    register is unaffected.
//  - Reset mid-operation: pending bundle dropped, credits lost; requesters must re-issue.
// STRUCTURE
//  - No shared package types needed; widths derived from parameters. nports/nreq
//    localparams for grant-count width ($clog2(nports+1)) kept local.
//  - Sub-module l1_rd_credit: credit counter array (add/sub/clear/saturate), nstrms
//    instances of cnt_width counters, consumes per-stream used counts.
//  - Top: rotate requests by rr, sequential-prefix grant loop (generate), per-port sid
//    select, output register, rr update.
// TESTING
//  1 Reset, add 4 credits to sid 3, requesters 0..3 request sid 3 -> one bundle, acts=0x0F,
//    all sids 3, credit[3]=0, i_req_r=0x0F.
//  2 credit[5]=2, requesters 0..3 request sid 5 -> only requesters 0,1 granted; next cycle
//    2,3 still pending and stalled until credits added.
//  3 nreq=8 all valid, distinct sids with credits, nports=4 -> cycle1 grants 0..3, rr=4,
//    cycle2 grants 4..7, rr=0.
//  4 o_rd_r held low 3 cycles with pending requests -> bundle stable, i_req_r=0, credits
//    unchanged; release -> next bundle follows 1 cycle later.
//  5 Same cycle: credit[2]=1, i_cr_v sid 2 cnt 3, one grant to 2 -> credit[2]=3; with
//    i_clr[2] also high -> no grant to 2, credit[2]=0.
//  6 credit[1]=250 (cnt_width 8), add 10 -> credit[1]=255; reset mid-stall -> o_rd_v=0,
//    all credits 0.

Source files
------------

// File: rtl/l1_rd_sched_pkg.sv
// Shared defaults and helpers for the L1 read-port scheduler.
package l1_rd_sched_pkg;

  localparam int DefNstrms   = 64;
  localparam int DefNports   = 8;
  localparam int DefNreq     = 8;
  localparam int DefCntWidth = 8;

  // Width needed to count 0..n grants
  function automatic int grantWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/l1_rd_sched_if.sv
// Request and bundle handshake bus between requesters, the scheduler and the L1 read-port array.
interface l1_rd_sched_if
  import l1_rd_sched_pkg::*;
#(
  parameter int nreq   = DefNreq,
  parameter int nports = DefNports,
  parameter int sw     = $clog2(DefNstrms)
);

  logic [nreq-1:0]      i_req_v;
  logic [nreq-1:0]      i_req_r;
  logic [nreq*sw-1:0]   i_req_sid;
  logic                 o_rd_v;
  logic                 o_rd_r;
  logic [nports-1:0]    o_rd_acts;
  logic [nports*sw-1:0] o_rd_sids;

  modport slave (
    input  i_req_v, i_req_sid, o_rd_r,
    output i_req_r, o_rd_v, o_rd_acts, o_rd_sids
  );

  modport master (
    output i_req_v, i_req_sid, o_rd_r,
    input  i_req_r, o_rd_v, o_rd_acts, o_rd_sids
  );

endinterface

// File: rtl/l1_rd_sched_credit.sv
// Per-stream read credit counters: add, consume, clear and saturate once per cycle.
module l1_rd_credit
  import l1_rd_sched_pkg::*;
#(
  parameter int nstrms       = DefNstrms,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int cnt_width    = DefCntWidth,
  parameter int uw           = grantWidth(DefNports)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_cr_v,
  input  logic [nstrms_width-1:0]     i_cr_sid,
  input  logic [cnt_width-1:0]        i_cr_cnt,
  input  logic [nstrms-1:0]           i_clr,
  input  logic [nstrms*uw-1:0]        i_used,
  output logic [nstrms*cnt_width-1:0] o_credits
);

  localparam int sumw = cnt_width + 2;
  localparam logic [sumw-1:0] satMax = {2'b00, {cnt_width{1'b1}}};

  for (genvar s = 0; s < nstrms; s++) begin : g_cnt
    logic [cnt_width-1:0] r_cnt;
    logic [sumw-1:0]      w_sum;

    // Used never exceeds the current count, so subtracting first cannot wrap
    always_comb begin
      w_sum = {2'b00, r_cnt} - sumw'(i_used[s*uw +: uw]);
      if (i_cr_v && (i_cr_sid == nstrms_width'(s)))
        w_sum = w_sum + {2'b00, i_cr_cnt};
    end

    always_ff @(posedge clk) begin
      if (reset || i_clr[s])
        r_cnt <= '0;
      else if (w_sum > satMax)
        r_cnt <= '1;
      else
        r_cnt <= w_sum[cnt_width-1:0];
    end

    assign o_credits[s*cnt_width +: cnt_width] = r_cnt;
  end

endmodule

// File: rtl/l1_rd_sched.sv
// L1 read-port scheduler: round-robin, credit-gated grants of up to nports reads per cycle,
// presented as one registered bundle of per-port act/sid.
module l1_rd_sched
  import l1_rd_sched_pkg::*;
#(
  parameter int nstrms       = DefNstrms,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int nports       = DefNports,
  parameter int nreq         = DefNreq,
  parameter int cnt_width    = DefCntWidth
) (
  input  logic                        clk,
  input  logic                        reset,
  l1_rd_sched_if.slave                bus,
  input  logic                        i_cr_v,
  input  logic [nstrms_width-1:0]     i_cr_sid,
  input  logic [cnt_width-1:0]        i_cr_cnt,
  input  logic [nstrms-1:0]           i_clr,
  output logic [nstrms*cnt_width-1:0] o_credits
);

  localparam int sw = nstrms_width;
  localparam int uw = grantWidth(nports);
  localparam int rw = (nreq > 1) ? $clog2(nreq) : 1;

  logic [rw-1:0]          r_rrPtr;
  logic                   r_rdV;
  logic [nports-1:0]      r_rdActs;
  logic [nports*sw-1:0]   r_rdSids;

  logic                   w_stall;
  logic [31:0]            w_sidShift;
  logic [nreq-1:0]        w_rotV;
  logic [nreq*sw-1:0]     w_rotSid;
  logic [nreq-1:0]        w_rotGnt;
  logic [nports-1:0]      w_acts;
  logic [nports*sw-1:0]   w_sids;
  logic [rw-1:0]          w_rrNext;
  logic [nstrms*uw-1:0]   w_used;

  assign w_stall = r_rdV & ~bus.o_rd_r;

  // Rotate so rotated index 0 is the requester at the round-robin pointer
  assign w_sidShift = 32'(r_rrPtr) * sw;
  assign w_rotV     = nreq'({bus.i_req_v, bus.i_req_v} >> r_rrPtr);
  assign w_rotSid   = (nreq*sw)'({bus.i_req_sid, bus.i_req_sid} >> w_sidShift);

  always_comb begin
    int cnt;
    int same;
    int last;
    logic [sw-1:0]        sid;
    logic [cnt_width-1:0] cred;
    w_rotGnt = '0;
    w_acts   = '0;
    w_sids   = '0;
    cnt      = 0;
    same     = 0;
    last     = 0;
    sid      = '0;
    cred     = '0;
    for (int i = 0; i < nreq; i++) begin
      sid  = w_rotSid[i*sw +: sw];
      cred = o_credits[32'(sid)*cnt_width +: cnt_width];
      same = 0;
      for (int k = 0; k < nports; k++)
        if (k < cnt && w_sids[k*sw +: sw] == sid)
          same++;
      if (!w_stall && w_rotV[i] && cnt < nports && !i_clr[sid] && 32'(cred) > same) begin
        w_rotGnt[i] = 1'b1;
        for (int k = 0; k < nports; k++)
          if (k == cnt) begin
            w_acts[k]           = 1'b1;
            w_sids[k*sw +: sw]  = sid;
          end
        cnt++;
        last = i;
      end
    end
    w_rrNext = rw'((32'(r_rrPtr) + 32'(last) + 32'd1) % nreq);
  end

  assign bus.i_req_r = nreq'(({w_rotGnt, w_rotGnt} << r_rrPtr) >> nreq);

  always_comb begin
    w_used = '0;
    for (int s = 0; s < nstrms; s++)
      for (int k = 0; k < nports; k++)
        if (w_acts[k] && w_sids[k*sw +: sw] == sw'(s))
          w_used[s*uw +: uw] = w_used[s*uw +: uw] + uw'(1);
  end

  l1_rd_credit #(
    .nstrms       (nstrms),
    .nstrms_width (sw),
    .cnt_width    (cnt_width),
    .uw           (uw)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .i_cr_v    (i_cr_v),
    .i_cr_sid  (i_cr_sid),
    .i_cr_cnt  (i_cr_cnt),
    .i_clr     (i_clr),
    .i_used    (w_used),
    .o_credits (o_credits)
  );

  // A stalled bundle stays put; otherwise every cycle reloads, including an empty bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdV    <= 1'b0;
      r_rdActs <= '0;
      r_rdSids <= '0;
      r_rrPtr  <= '0;
    end else begin
      if (!w_stall) begin
        r_rdV    <= |w_acts;
        r_rdActs <= w_acts;
        r_rdSids <= w_sids;
      end
      if (|w_rotGnt)
        r_rrPtr <= w_rrNext;
    end
  end

  assign bus.o_rd_v    = r_rdV;
  assign bus.o_rd_acts = r_rdActs;
  assign bus.o_rd_sids = r_rdSids;

endmodule

// File: tb/tb_l1_rd_sched.sv
// Directed bench for l1_rd_sched with a per-cycle reference model of the scheduling rules.
module tb_l1_rd_sched;

  localparam int NSTRMS = 64;
  localparam int SW     = 6;
  localparam int NPORTS = 4;
  localparam int NREQ   = 8;
  localparam int CW     = 8;
  localparam int CMAX   = 255;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 crV;
  logic [SW-1:0]        crSid;
  logic [CW-1:0]        crCnt;
  logic [NSTRMS-1:0]    clr;
  logic [NSTRMS*CW-1:0] credits;

  int checks   = 0;
  int failures = 0;

  l1_rd_sched_if #(.nreq(NREQ), .nports(NPORTS), .sw(SW)) bus ();

  l1_rd_sched #(
    .nstrms       (NSTRMS),
    .nstrms_width (SW),
    .nports       (NPORTS),
    .nreq         (NREQ),
    .cnt_width    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .i_cr_v    (crV),
    .i_cr_sid  (crSid),
    .i_cr_cnt  (crCnt),
    .i_clr     (clr),
    .o_credits (credits)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v,
                               input logic [NREQ*SW-1:0] sids, input logic cv, input int cs,
                               input int cc, input logic [NSTRMS-1:0] cl, input logic rdR);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.i_req_v   = v;
    bus.i_req_sid = sids;
    crV           = cv;
    crSid         = SW'(cs);
    crCnt         = CW'(cc);
    clr           = cl;
    bus.o_rd_r    = rdR;
  endtask

  function automatic logic [NREQ*SW-1:0] sidsAll(input int s);
    logic [NREQ*SW-1:0] r;
    r = '0;
    for (int j = 0; j < NREQ; j++) r[j*SW +: SW] = SW'(s);
    return r;
  endfunction

  function automatic logic [NREQ*SW-1:0] sidsSeq(input int base);
    logic [NREQ*SW-1:0] r;
    r = '0;
    for (int j = 0; j < NREQ; j++) r[j*SW +: SW] = SW'(base + j);
    return r;
  endfunction

  function automatic logic [CW-1:0] credOf(input int s);
    return credits[s*CW +: CW];
  endfunction

  // Reference model state: credits per stream, rr pointer, and the registered bundle
  int mCred[NSTRMS];
  int nCred[NSTRMS];
  int mRr, nRr;
  bit mRdV, nRdV;
  int mCnt, nCnt;
  int mSids[NPORTS];
  int nSids[NPORTS];
  bit nextValid = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      nextValid = 1'b0;
    end else begin
      int used[NSTRMS];
      int gSids[NPORTS];
      int cnt, last, j, sid, val, add;
      bit stall;
      logic [NREQ-1:0]      expR;
      logic [NPORTS-1:0]    expActs;
      logic [NPORTS*SW-1:0] expSids;
      logic [NSTRMS*CW-1:0] expCred;
      for (int s = 0; s < NSTRMS; s++) used[s] = 0;
      for (int k = 0; k < NPORTS; k++) gSids[k] = 0;
      cnt = 0; last = 0; expR = '0;
      stall = mRdV && !bus.o_rd_r;
      if (!stall) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (mRr + i) % NREQ;
          sid = int'(bus.i_req_sid[j*SW +: SW]);
          if (bus.i_req_v[j] && cnt < NPORTS && !clr[sid] && mCred[sid] > used[sid]) begin
            expR[j] = 1'b1;
            gSids[cnt] = sid;
            cnt++;
            used[sid]++;
            last = j;
          end
        end
      end
      expActs = '0; expSids = '0; expCred = '0;
      for (int k = 0; k < mCnt; k++) begin
        expActs[k] = 1'b1;
        expSids[k*SW +: SW] = SW'(mSids[k]);
      end
      for (int s = 0; s < NSTRMS; s++) expCred[s*CW +: CW] = CW'(mCred[s]);
      checkOutput("cyc_req_r", bus.i_req_r, expR);
      checkOutput("cyc_rd_v", bus.o_rd_v, mRdV);
      checkOutput("cyc_rd_acts", bus.o_rd_acts, expActs);
      checkOutput("cyc_rd_sids", bus.o_rd_sids, expSids);
      checkOutput("cyc_credits", credits, expCred);
      for (int s = 0; s < NSTRMS; s++) begin
        add = (crV && int'(crSid) == s) ? int'(crCnt) : 0;
        val = mCred[s] + add - used[s];
        if (val > CMAX) val = CMAX;
        nCred[s] = clr[s] ? 0 : val;
      end
      if (stall) begin
        nRdV = mRdV; nCnt = mCnt; nSids = mSids;
      end else begin
        nRdV = (cnt > 0); nCnt = cnt; nSids = gSids;
      end
      nRr = (cnt > 0) ? (last + 1) % NREQ : mRr;
      nextValid = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSTRMS; s++) mCred[s] = 0;
      for (int k = 0; k < NPORTS; k++) mSids[k] = 0;
      mRr = 0; mRdV = 1'b0; mCnt = 0;
    end else if (nextValid) begin
      mCred = nCred; mSids = nSids;
      mRr = nRr; mRdV = nRdV; mCnt = nCnt;
    end
  end

  initial begin
    reset = 1'b1; crV = 1'b0; crSid = '0; crCnt = '0; clr = '0;
    bus.i_req_v = '0; bus.i_req_sid = '0; bus.o_rd_r = 1'b1;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("rst_rd_v", bus.o_rd_v, 0);
    checkOutput("rst_acts", bus.o_rd_acts, 0);
    checkOutput("rst_sids", bus.o_rd_sids, 0);
    checkOutput("rst_credits", credits, 0);
    checkOutput("rst_req_r", bus.i_req_r, 0);

    // Four grants to one stream fill ports 0..3
    applyStimulus(0, 0, 0, 1, 3, 4, 0, 1);
    applyStimulus(0, 8'h0F, sidsAll(3), 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t1_req_r", bus.i_req_r, 8'h0F);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t1_rd_v", bus.o_rd_v, 1);
    checkOutput("t1_acts", bus.o_rd_acts, 4'hF);
    checkOutput("t1_sids", bus.o_rd_sids, 24'h0C30C3);
    checkOutput("t1_cred3", credOf(3), 0);

    // Credits limit same-stream grants; fresh credits usable only next cycle
    applyStimulus(0, 0, 0, 1, 5, 2, 0, 1);
    applyStimulus(0, 8'h0F, sidsAll(5), 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t2_req_r", bus.i_req_r, 8'h03);
    applyStimulus(0, 8'h0C, sidsAll(5), 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t2_blocked_req_r", bus.i_req_r, 0);
    checkOutput("t2_acts", bus.o_rd_acts, 4'h3);
    checkOutput("t2_sids", bus.o_rd_sids, 24'h000145);
    applyStimulus(0, 8'h0C, sidsAll(5), 1, 5, 2, 0, 1);
    @(negedge clk); checkOutput("t2_newcr_req_r", bus.i_req_r, 0);
    applyStimulus(0, 8'h0C, sidsAll(5), 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t2_resume_req_r", bus.i_req_r, 8'h0C);

    // Port cap and round-robin rotation with eight distinct streams
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    for (int s = 0; s < 8; s++) applyStimulus(0, 0, 0, 1, 10 + s, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 20, 8, 0, 1);
    applyStimulus(0, 8'hFF, sidsSeq(10), 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t3_c1_req_r", bus.i_req_r, 8'h0F);
    applyStimulus(0, 8'hF0, sidsSeq(10), 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t3_c2_req_r", bus.i_req_r, 8'hF0);
    checkOutput("t3_c1_sids", bus.o_rd_sids, 24'h34C2CA);
    applyStimulus(0, 8'hFF, sidsAll(20), 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t3_rr0_req_r", bus.i_req_r, 8'h0F);
    checkOutput("t3_c2_sids", bus.o_rd_sids, 24'h4503CE);

    // Downstream stall holds the bundle and blocks grants
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 8'hF0, sidsAll(20), 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_hold_req_r", bus.i_req_r, 0);
      checkOutput("t4_hold_acts", bus.o_rd_acts, 4'hF);
      checkOutput("t4_hold_sids", bus.o_rd_sids, 24'h514514);
      checkOutput("t4_hold_cred20", credOf(20), 4);
    end
    applyStimulus(0, 8'hF0, sidsAll(20), 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t4_release_req_r", bus.i_req_r, 8'hF0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t4_next_v", bus.o_rd_v, 1);
    checkOutput("t4_next_acts", bus.o_rd_acts, 4'hF);
    checkOutput("t4_cred20", credOf(20), 0);

    // Same-cycle add and consume, then clear overriding both
    applyStimulus(0, 0, 0, 1, 2, 1, 0, 1);
    applyStimulus(0, 8'h01, sidsAll(2), 1, 2, 3, 0, 1);
    @(negedge clk); checkOutput("t5_req_r", bus.i_req_r, 8'h01);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t5_cred2", credOf(2), 3);
    checkOutput("t5_acts", bus.o_rd_acts, 4'h1);
    checkOutput("t5_sids", bus.o_rd_sids, 24'h000002);
    applyStimulus(0, 8'h01, sidsAll(2), 1, 2, 3, 64'h4, 1);
    @(negedge clk); checkOutput("t5_clr_req_r", bus.i_req_r, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); checkOutput("t5_clr_cred2", credOf(2), 0);

    // Saturation, then reset while a bundle is stalled
    applyStimulus(0, 0, 0, 1, 1, 250, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 10, 0, 1);
    @(negedge clk); checkOutput("t6_cred1_pre", credOf(1), 250);
    applyStimulus(0, 8'h01, sidsAll(1), 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t6_cred1_sat", credOf(1), 255);
    checkOutput("model_cred1_sat", mCred[1], 255);
    checkOutput("t6_req_r", bus.i_req_r, 8'h01);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("t6_stall_v", bus.o_rd_v, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t6_rst_v", bus.o_rd_v, 0);
    checkOutput("t6_rst_credits", credits, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
